// File: rtl/oled_init_sequencer_if.sv
// SPI shifter handshake and pixel-source stream bundled for the OLED init sequencer.
// The master side is the sequencer; the slave side is the shifter plus pixel source.
interface oled_init_sequencer_if;
  logic       spi_load;
  logic [7:0] spi_byte;
  logic       spi_done;
  logic       oled_dc;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;

  modport master (
    output spi_load, spi_byte, oled_dc, pix_ready,
    input  spi_done, pix_data, pix_valid
  );

  modport slave (
    input  spi_load, spi_byte, oled_dc, pix_ready,
    output spi_done, pix_data, pix_valid
  );
endinterface

// File: rtl/oled_init_sequencer.sv
// SSD1306 power-up / init sequencer feeding the SPI byte shifter.
// Brings up VDD, pulses panel reset, sends the fixed command list around the VBAT
// enable, then streams display bytes from the pixel source. All bytes share one
// load/done handshake engine.
module oled_init_sequencer #(
  parameter int PWR_DELAY  = 100_000,
  parameter int RST_CYCLES = 100_000,
  parameter int VBAT_DELAY = 10_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  oled_init_sequencer_if.master bus,
  output logic                  oled_res,
  output logic                  oled_vdd_n,
  output logic                  oled_vbat_n,
  output logic                  init_done
);

  localparam int CNT_W = $clog2(VBAT_DELAY + 1);
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_DELAY - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] VBAT_LAST = CNT_W'(VBAT_DELAY - 1);

  // Last ROM index of each command group.
  localparam logic [3:0] IDX_A_LAST = 4'd0;
  localparam logic [3:0] IDX_B_LAST = 4'd4;
  localparam logic [3:0] IDX_C_LAST = 4'd11;

  typedef enum logic [2:0] {
    ST_PWR_UP, ST_CMD_A, ST_RST_LO, ST_RST_HI,
    ST_CMD_B, ST_VBAT, ST_CMD_C, ST_STREAM
  } state_t;

  typedef enum logic [1:0] {
    SND_IDLE, SND_LOAD, SND_RELEASE
  } snd_t;

  state_t           state_q;
  snd_t             snd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       rom_idx_q;
  logic             done_s1_q, done_s2_q;
  logic             spi_load_q, oled_dc_q, pix_ready_q;
  logic [7:0]       spi_byte_q;
  logic             res_q, vdd_n_q, vbat_n_q, init_done_q;

  logic             done_sync;
  logic             cmd_state;
  logic [3:0]       cmd_last;
  state_t           cmd_next;
  logic [7:0]       rom_byte;

  assign done_sync = done_s2_q;

  // Fixed init command list, indexed in transmit order.
  always_comb begin
    rom_byte = 8'h00;
    case (rom_idx_q)
      4'd0:    rom_byte = 8'hAE;
      4'd1:    rom_byte = 8'h8D;
      4'd2:    rom_byte = 8'h14;
      4'd3:    rom_byte = 8'hD9;
      4'd4:    rom_byte = 8'hF1;
      4'd5:    rom_byte = 8'h81;
      4'd6:    rom_byte = 8'h0F;
      4'd7:    rom_byte = 8'hA0;
      4'd8:    rom_byte = 8'hC0;
      4'd9:    rom_byte = 8'hDA;
      4'd10:   rom_byte = 8'h00;
      4'd11:   rom_byte = 8'hAF;
      default: rom_byte = 8'h00;
    endcase
  end

  // Where the current command group ends and which state follows it.
  always_comb begin
    cmd_state = 1'b0;
    cmd_last  = IDX_A_LAST;
    cmd_next  = ST_RST_LO;
    case (state_q)
      ST_CMD_A: begin cmd_state = 1'b1; cmd_last = IDX_A_LAST; cmd_next = ST_RST_LO; end
      ST_CMD_B: begin cmd_state = 1'b1; cmd_last = IDX_B_LAST; cmd_next = ST_VBAT;   end
      ST_CMD_C: begin cmd_state = 1'b1; cmd_last = IDX_C_LAST; cmd_next = ST_STREAM; end
      default:  ;
    endcase
  end

  // Two-flop synchroniser for the shifter's done flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
    end else begin
      done_s1_q <= bus.spi_done;
      done_s2_q <= done_s1_q;
    end
  end

  // Main sequencer, delay counter and byte-send handshake with registered outputs.
  // Rail and reset pins are decoded from the state one cycle late so each pin
  // changes exactly when its state has been in effect for one full cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_PWR_UP;
      snd_q       <= SND_IDLE;
      cnt_q       <= '0;
      rom_idx_q   <= 4'd0;
      spi_load_q  <= 1'b0;
      spi_byte_q  <= 8'h00;
      oled_dc_q   <= 1'b0;
      pix_ready_q <= 1'b0;
      res_q       <= 1'b1;
      vdd_n_q     <= 1'b1;
      vbat_n_q    <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      pix_ready_q <= 1'b0;
      vdd_n_q     <= 1'b0;
      vbat_n_q    <= !(state_q == ST_VBAT || state_q == ST_CMD_C || state_q == ST_STREAM);
      res_q       <= (state_q != ST_RST_LO);

      // Timed waits: exactly N cycles in the state.
      case (state_q)
        ST_PWR_UP: begin
          if (cnt_q == PWR_LAST) begin state_q <= ST_CMD_A; cnt_q <= '0; end
          else cnt_q <= cnt_q + 1'b1;
        end
        ST_RST_LO: begin
          if (cnt_q == RST_LAST) begin state_q <= ST_RST_HI; cnt_q <= '0; end
          else cnt_q <= cnt_q + 1'b1;
        end
        ST_RST_HI: begin
          if (cnt_q == RST_LAST) begin state_q <= ST_CMD_B; cnt_q <= '0; end
          else cnt_q <= cnt_q + 1'b1;
        end
        ST_VBAT: begin
          if (cnt_q == VBAT_LAST) begin state_q <= ST_CMD_C; cnt_q <= '0; end
          else cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase

      // Byte handshake; a stale done keeps IDLE from loading until it drops.
      case (snd_q)
        SND_IDLE: begin
          if (!done_sync) begin
            if (cmd_state) begin
              spi_byte_q <= rom_byte;
              oled_dc_q  <= 1'b0;
              spi_load_q <= 1'b1;
              snd_q      <= SND_LOAD;
            end else if (state_q == ST_STREAM && bus.pix_valid) begin
              spi_byte_q  <= bus.pix_data;
              oled_dc_q   <= 1'b1;
              spi_load_q  <= 1'b1;
              pix_ready_q <= 1'b1;
              snd_q       <= SND_LOAD;
            end
          end
        end
        SND_LOAD: begin
          if (done_sync) begin
            spi_load_q <= 1'b0;
            snd_q      <= SND_RELEASE;
          end
        end
        SND_RELEASE: begin
          if (!done_sync) begin
            snd_q <= SND_IDLE;
            if (cmd_state) begin
              rom_idx_q <= rom_idx_q + 4'd1;
              if (rom_idx_q == cmd_last) begin
                state_q <= cmd_next;
                cnt_q   <= '0;
                if (state_q == ST_CMD_C) init_done_q <= 1'b1;
              end
            end
          end
        end
        default: snd_q <= SND_IDLE;
      endcase
    end
  end

  assign bus.spi_load  = spi_load_q;
  assign bus.spi_byte  = spi_byte_q;
  assign bus.oled_dc   = oled_dc_q;
  assign bus.pix_ready = pix_ready_q;
  assign oled_res      = res_q;
  assign oled_vdd_n    = vdd_n_q;
  assign oled_vbat_n   = vbat_n_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Directed bench for oled_init_sequencer with a behavioural SPI shifter model.
module tb_oled_init_sequencer;
  localparam int PWR  = 10;
  localparam int RSTC = 5;
  localparam int VBAT = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  oled_init_sequencer_if bus();
  logic oled_res, oled_vdd_n, oled_vbat_n, init_done;

  oled_init_sequencer #(.PWR_DELAY(PWR), .RST_CYCLES(RSTC), .VBAT_DELAY(VBAT)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .oled_res(oled_res), .oled_vdd_n(oled_vdd_n),
    .oled_vbat_n(oled_vbat_n), .init_done(init_done)
  );

  logic model_done = 1'b0;
  logic stale_done = 1'b0;
  int   lat = 8;
  assign bus.spi_done = model_done | stale_done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor state
  logic [7:0] log_byte[$];
  logic       log_dc[$];
  int   load_rise_cyc = 0, last_load_len = 0;
  int   vdd_fall_cyc = -1, res_fall_cyc = -1, res_rise_cyc = -1, vbat_fall_cyc = -1;
  int   cae = -1, c8d = -1, cf1 = -1, c81 = -1;
  int   viol_rise = 0, viol_stable = 0, pix_cnt = 0;
  logic [7:0] hold_byte = 8'h00;
  logic       hold_dc = 1'b0;
  logic prev_load = 1'b0, prev_vdd = 1'b1, prev_res = 1'b1, prev_vbat = 1'b1;

  // Shifter model: raise done lat cycles after load, drop it once load falls.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.spi_load === 1'b1) begin
        repeat (lat) @(negedge clock);
        model_done = 1'b1;
        while (bus.spi_load === 1'b1) @(negedge clock);
        @(negedge clock);
        model_done = 1'b0;
      end
    end
  end

  // Passive monitor sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.spi_load === 1'b1 && !prev_load) begin
        log_byte.push_back(bus.spi_byte);
        log_dc.push_back(bus.oled_dc);
        load_rise_cyc = cyc;
        if (bus.spi_done !== 1'b0) viol_rise++;
        hold_byte = bus.spi_byte;
        hold_dc   = bus.oled_dc;
        if (bus.oled_dc === 1'b0) begin
          if (bus.spi_byte == 8'hAE) cae = cyc;
          if (bus.spi_byte == 8'h8D) c8d = cyc;
          if (bus.spi_byte == 8'hF1) cf1 = cyc;
          if (bus.spi_byte == 8'h81) c81 = cyc;
        end
      end else if (bus.spi_load === 1'b1 && prev_load) begin
        if (bus.spi_byte !== hold_byte || bus.oled_dc !== hold_dc) viol_stable++;
      end
      if (bus.spi_load !== 1'b1 && prev_load) last_load_len = cyc - load_rise_cyc;
      if (oled_vdd_n === 1'b0 && prev_vdd) vdd_fall_cyc = cyc;
      if (oled_res === 1'b0 && prev_res) res_fall_cyc = cyc;
      if (oled_res === 1'b1 && !prev_res) res_rise_cyc = cyc;
      if (oled_vbat_n === 1'b0 && prev_vbat) vbat_fall_cyc = cyc;
      if (bus.pix_ready === 1'b1) pix_cnt++;
      prev_load = (bus.spi_load === 1'b1);
      prev_vdd  = (oled_vdd_n !== 1'b0);
      prev_res  = (oled_res !== 1'b0);
      prev_vbat = (oled_vbat_n !== 1'b0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (bus.spi_load === 1'b0 && bus.spi_done === 1'b0) break;
      step(1);
    end
    n_checks++;
    if (bus.spi_load !== 1'b0 || bus.spi_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: load=%b done=%b after %0d cycles, required both 0", name, bus.spi_load, bus.spi_done, limit);
    end
    step(6);
  endtask

  task automatic check_reset_outputs(input string name);
    logic [13:0] got;
    got = {bus.spi_load, bus.spi_byte, bus.oled_dc, oled_res, oled_vdd_n, oled_vbat_n, bus.pix_ready};
    n_checks++;
    if (got !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_outputs: load,byte,dc,res,vdd_n,vbat_n,ready=%b required 0_00000000_0_1_1_1_0", name, got);
    end
    n_checks++;
    if (init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_init_done: got %b required 0", name, init_done);
    end
  endtask

  task automatic test_reset();
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    step(3);
    check_reset_outputs("reset");
    $display("test_reset: reset values checked");
  endtask

  task automatic test_power_up();
    int i;
    bus.pix_data  = 8'h5A;
    bus.pix_valid = 1'b1;
    reset = 1'b1;
    for (i = 0; i < 200 && log_byte.size() == 0; i++) step(1);
    n_checks++;
    if (log_byte.size() < 1 || log_byte[0] !== 8'hAE || log_dc[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL first_cmd: entries=%0d byte=%h dc=%b required AE dc=0", log_byte.size(), log_byte.size() ? log_byte[0] : 8'h00, log_dc.size() ? log_dc[0] : 1'b0);
    end
    n_checks++;
    if (load_rise_cyc - vdd_fall_cyc != PWR) begin
      n_fail++;
      $display("FAIL pwr_delay: vdd fall to first load %0d cycles, required %0d", load_rise_cyc - vdd_fall_cyc, PWR);
    end
    $display("test_power_up: first byte %h after %0d cycles", hold_byte, load_rise_cyc - vdd_fall_cyc);
  endtask

  task automatic test_init_sequence();
    logic [7:0] exp_bytes [0:11];
    int i;
    exp_bytes = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
    for (i = 0; i < 3000 && init_done !== 1'b1; i++) step(1);
    n_checks++;
    if (init_done !== 1'b1 || log_byte.size() != 12 || bus.spi_load !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done: done=%b entries=%0d load=%b required 1, 12, 0", init_done, log_byte.size(), bus.spi_load);
    end
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (k >= log_byte.size() || log_byte[k] !== exp_bytes[k] || log_dc[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL cmd_%0d: got %h dc=%b required %h dc=0", k, k < log_byte.size() ? log_byte[k] : 8'h00, k < log_dc.size() ? log_dc[k] : 1'b0, exp_bytes[k]);
      end
    end
    n_checks++;
    if (res_rise_cyc - res_fall_cyc != RSTC || res_fall_cyc <= cae || res_rise_cyc >= c8d) begin
      n_fail++;
      $display("FAIL res_pulse: low %0d cycles (fall %0d rise %0d, AE %0d 8D %0d) required %0d between AE and 8D", res_rise_cyc - res_fall_cyc, res_fall_cyc, res_rise_cyc, cae, c8d, RSTC);
    end
    n_checks++;
    if (c81 - vbat_fall_cyc != VBAT || vbat_fall_cyc <= cf1) begin
      n_fail++;
      $display("FAIL vbat_delay: vbat fall %0d F1 %0d 81 %0d gap %0d required %0d after F1", vbat_fall_cyc, cf1, c81, c81 - vbat_fall_cyc, VBAT);
    end
    n_checks++;
    if (pix_cnt != 0) begin
      n_fail++;
      $display("FAIL pix_during_init: pix_ready pulses %0d required 0", pix_cnt);
    end
    $display("test_init_sequence: %0d command bytes, res low %0d, vbat gap %0d", log_byte.size(), res_rise_cyc - res_fall_cyc, c81 - vbat_fall_cyc);
  endtask

  task automatic test_first_pixel();
    int i;
    for (i = 0; i < 50 && bus.pix_ready !== 1'b1; i++) step(1);
    bus.pix_valid = 1'b0;
    wait_idle("first_pixel", 100);
    n_checks++;
    if (log_byte.size() != 13 || log_byte[log_byte.size()-1] !== 8'h5A || log_dc[log_dc.size()-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_pixel: entries=%0d last=%h dc=%b required 13 entries, 5A dc=1", log_byte.size(), log_byte[log_byte.size()-1], log_dc[log_dc.size()-1]);
    end
    n_checks++;
    if (pix_cnt != 1) begin
      n_fail++;
      $display("FAIL first_pixel_ready: pulses %0d required 1", pix_cnt);
    end
    $display("test_first_pixel: byte 5A streamed, pix_ready pulses %0d", pix_cnt);
  endtask

  task automatic test_back_to_back();
    int base, pc0, n, i;
    base = log_byte.size();
    pc0  = pix_cnt;
    n    = 0;
    bus.pix_data  = 8'h01;
    bus.pix_valid = 1'b1;
    for (i = 0; i < 400 && n < 3; i++) begin
      step(1);
      if (bus.pix_ready === 1'b1) begin
        n++;
        if (n == 3) bus.pix_valid = 1'b0;
        else bus.pix_data = 8'(n + 1);
      end
    end
    bus.pix_valid = 1'b0;
    wait_idle("back_to_back", 100);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (base + k >= log_byte.size() || log_byte[base+k] !== 8'(k + 1) || log_dc[base+k] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_byte_%0d: got %h required %h dc=1", k, base + k < log_byte.size() ? log_byte[base+k] : 8'h00, 8'(k + 1));
      end
    end
    n_checks++;
    if (pix_cnt - pc0 != 3 || log_byte.size() - base != 3) begin
      n_fail++;
      $display("FAIL b2b_count: ready pulses %0d transfers %0d required 3 and 3", pix_cnt - pc0, log_byte.size() - base);
    end
    n_checks++;
    if (viol_rise != 0) begin
      n_fail++;
      $display("FAIL load_before_done_low: violations %0d required 0", viol_rise);
    end
    $display("test_back_to_back: %0d transfers", log_byte.size() - base);
  endtask

  task automatic test_long_wait();
    int i;
    lat = 100;
    bus.pix_data  = 8'hC3;
    bus.pix_valid = 1'b1;
    for (i = 0; i < 50 && bus.pix_ready !== 1'b1; i++) step(1);
    bus.pix_valid = 1'b0;
    wait_idle("long_wait", 400);
    lat = 8;
    n_checks++;
    if (last_load_len < 100 || log_byte[log_byte.size()-1] !== 8'hC3) begin
      n_fail++;
      $display("FAIL long_wait: load held %0d cycles byte %h required >=100 and C3", last_load_len, log_byte[log_byte.size()-1]);
    end
    n_checks++;
    if (viol_stable != 0) begin
      n_fail++;
      $display("FAIL load_stable: byte/dc changes while loading %0d required 0", viol_stable);
    end
    $display("test_long_wait: load held %0d cycles", last_load_len);
  endtask

  task automatic test_stale_done();
    int pc0, n0, i;
    stale_done = 1'b1;
    step(4);
    pc0 = pix_cnt;
    n0  = log_byte.size();
    bus.pix_data  = 8'h77;
    bus.pix_valid = 1'b1;
    step(20);
    n_checks++;
    if (pix_cnt != pc0 || log_byte.size() != n0) begin
      n_fail++;
      $display("FAIL stale_done_hold: ready pulses %0d loads %0d while done stale, required 0 and 0", pix_cnt - pc0, log_byte.size() - n0);
    end
    stale_done = 1'b0;
    for (i = 0; i < 20 && bus.pix_ready !== 1'b1; i++) step(1);
    bus.pix_valid = 1'b0;
    wait_idle("stale_done", 100);
    n_checks++;
    if (log_byte.size() != n0 + 1 || log_byte[log_byte.size()-1] !== 8'h77) begin
      n_fail++;
      $display("FAIL stale_done_resume: loads %0d last %h required 1 load of 77", log_byte.size() - n0, log_byte[log_byte.size()-1]);
    end
    $display("test_stale_done: transfer resumed after done dropped");
  endtask

  task automatic test_reset_mid_vbat();
    int i;
    bus.pix_valid = 1'b0;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    for (i = 0; i < 1000 && oled_vbat_n !== 1'b0; i++) step(1);
    step(5);
    n_checks++;
    if (oled_vbat_n !== 1'b0 || bus.spi_load !== 1'b0) begin
      n_fail++;
      $display("FAIL vbat_reach: vbat_n=%b load=%b required 0 and 0 in VBAT wait", oled_vbat_n, bus.spi_load);
    end
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    step(3);
    log_byte.delete();
    log_dc.delete();
    vdd_fall_cyc = -1;
    reset = 1'b1;
    for (i = 0; i < 200 && log_byte.size() == 0; i++) step(1);
    n_checks++;
    if (log_byte.size() < 1 || log_byte[0] !== 8'hAE || load_rise_cyc - vdd_fall_cyc != PWR) begin
      n_fail++;
      $display("FAIL restart: entries=%0d first=%h gap=%0d required AE after %0d", log_byte.size(), log_byte.size() ? log_byte[0] : 8'h00, load_rise_cyc - vdd_fall_cyc, PWR);
    end
    $display("test_reset_mid_vbat: restart first byte %h", log_byte.size() ? log_byte[0] : 8'h00);
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_init_sequence();
    test_first_pixel();
    test_back_to_back();
    test_long_wait();
    test_stale_done();
    test_reset_mid_vbat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
